bsk_ntw_client: RTL and testbench
=================================

Name: bsk_ntw_client

Overview:
- Downstream consumer of the BSK broadcast bus driven by all bsk_ntw_server instances (wire-OR; idle servers drive 0).
- Captures one batch of BSK coefficients per br_loop into a small multi-slot buffer.
- Checks bus ordering and integrity.
- Streams each completed batch to the NTT processing path with a valid/ready handshake, in arrival order.

Parameters:
- OP_W, 32, coefficient width.
- COEF_NB, 8, coefficients per bus beat (= BSK_DIST_COEF_NB).
- UNIT_NB, 4, unit index range per group (= BSK_UNIT_NB).
- GROUP_NB, 4, group index range per batch (= BSK_GROUP_NB).
- SLOT_NB, 2, number of batch buffers; power of 2, ≥2.
- BR_LOOP_W, 10, br_loop width (= LWE_K_W).
- Derived: ITER_NB = UNIT_NB*GROUP_NB beats per batch; RAM depth = SLOT_NB*ITER_NB.

Ports:
- clk  in  1  clock.
- s_rst_n  in  1  reset; asynchronous, active-low.
- srv_bdc_bsk  in  COEF_NB*OP_W  OR-ed broadcast coefficients.
- srv_bdc_avail  in  COEF_NB  per-coefficient valid.
- srv_bdc_unit  in  $clog2(UNIT_NB)  unit index of beat.
- srv_bdc_group  in  $clog2(GROUP_NB)  group index of beat.
- srv_bdc_br_loop  in  BR_LOOP_W  br_loop of beat.
- cl_bsk  out  COEF_NB*OP_W  output coefficients.
- cl_vld  out  1  output valid.
- cl_rdy  in  1  consumer ready.
- cl_br_loop  out  BR_LOOP_W  br_loop of the batch being output.
- cl_last  out  1  last beat of batch.
- error  out  4  {order_err, partial_err, loop_err, overflow_err}; sticky until reset.

Behaviour:
- Reset (async assert, sync deassert through the design's reset flop): all outputs 0; wp_slot = 0, rp_slot = 0, rp_beat = 0; all slots free; error = 0.
- Input stage: all srv_bdc_* registered once (s1). A beat is present when any avail bit is set.
- partial_err: set when a beat has avail neither all-ones nor all-zeros. The beat is still written.
- Write position: expected beat index wr_cnt (0..ITER_NB-1) within slot wp_slot. RAM address = wp_slot*ITER_NB + group*UNIT_NB + unit.
- order_err: set when group*UNIT_NB + unit ≠ wr_cnt. The data is written at the computed address.
- loop_err: on beat 0, br_loop is latched into slot_loop[wp_slot]. On any later beat, a br_loop differing from the latched value sets loop_err.
- Slot state: FREE → FILLING on beat 0 → FULL after beat ITER_NB-1 is written (wr_cnt wraps to 0, wp_slot increments mod SLOT_NB) → FREE after the consumer accepts its cl_last beat.
- overflow_err: set when beat 0 arrives and slot wp_slot is not FREE. The beat is dropped, the whole batch is discarded, and wr_cnt still advances so alignment is kept. The slot is unchanged.
- Read side: head slot rp_slot is readable only when FULL. RAM latency is 1. A 2-entry output skid buffer allows continuous streaming: one beat per cycle while cl_rdy = 1.
- cl_vld/cl_bsk/cl_br_loop/cl_last must stay stable while cl_vld=1 and cl_rdy=0.
- cl_last = 1 on beat ITER_NB-1. On that handshake, rp_slot increments mod SLOT_NB and the slot is freed.
- Latency: if the slot is head and the output is idle, the first cl_vld is asserted 4 cycles after the last beat of the batch is on srv_bdc_* (1 input reg, 1 write, 1 full→read issue, 1 RAM/output reg).
- Simultaneous events: a slot freed by cl_last and beat 0 targeting the same slot in the same cycle counts as FREE (no overflow). The write and read ports are independent; same-slot read-during-write cannot occur by construction.
- Reset mid-batch: the partial batch is discarded and the first post-reset beat is treated as beat 0 of slot 0.

Test Plan:
- Config COEF_NB=4, UNIT_NB=2, GROUP_NB=2 (ITER_NB=4), SLOT_NB=2. Send one batch br_loop=5, beats (g,u)=(0,0),(0,1),(1,0),(1,1), data = beat index replicated, cl_rdy=1 → cl_vld first asserted 4 cycles after the last beat; 4 consecutive beats with data 0..3, cl_br_loop=5, cl_last on 4th; error=0.
- Three back-to-back batches br_loop=1,2,3 with cl_rdy=0 → batches 1 and 2 stored; batch 3 sets overflow_err. After cl_rdy=1 the output is batches 1 and 2 only, in order.
- Beat order (0,0),(1,0),(0,1),(1,1) → order_err=1; output beat 1 holds the data sent with (1,0) at address 2? No: output reads by address, so beat index 2 holds (1,0) data. Checks the address rule.
- Beat with avail=4'b0011 → partial_err=1; other errors 0.
- Batch whose 3rd beat carries br_loop=6 instead of 5 → loop_err=1; cl_br_loop=5.
- Random cl_rdy toggling over 8 batches with the producer paced to avoid overflow → every beat output exactly once, stable under backpressure. Then assert s_rst_n=0 mid-batch, send a fresh batch → correct output and error=0.

Source files
------------

// File: rtl/bsk_ntw_client.sv
// BSK broadcast bus client: captures one coefficient batch per br_loop
// into a slot buffer and streams completed batches in arrival order.
module bsk_ntw_client #(
  parameter int OP_W      = 32,
  parameter int COEF_NB   = 8,
  parameter int UNIT_NB   = 4,
  parameter int GROUP_NB  = 4,
  parameter int SLOT_NB   = 2,
  parameter int BR_LOOP_W = 10
) (
  input  logic                         clk,
  input  logic                         s_rst_n,
  input  logic [COEF_NB*OP_W-1:0]      srv_bdc_bsk,
  input  logic [COEF_NB-1:0]           srv_bdc_avail,
  input  logic [$clog2(UNIT_NB)-1:0]   srv_bdc_unit,
  input  logic [$clog2(GROUP_NB)-1:0]  srv_bdc_group,
  input  logic [BR_LOOP_W-1:0]         srv_bdc_br_loop,
  output logic [COEF_NB*OP_W-1:0]      cl_bsk,
  output logic                         cl_vld,
  input  logic                         cl_rdy,
  output logic [BR_LOOP_W-1:0]         cl_br_loop,
  output logic                         cl_last,
  output logic [3:0]                   error
);

  localparam int ITER_NB = UNIT_NB * GROUP_NB;
  localparam int DEPTH   = SLOT_NB * ITER_NB;
  localparam int ITER_W  = (ITER_NB > 1) ? $clog2(ITER_NB) : 1;
  localparam int SLOT_W  = $clog2(SLOT_NB);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int DATA_W  = COEF_NB * OP_W;
  localparam int UNIT_W  = $clog2(UNIT_NB);
  localparam int GROUP_W = $clog2(GROUP_NB);

  typedef enum logic [1:0] {
    S_FREE, S_FILL, S_FULL, S_DRAIN
  } slot_st_t;

  logic r_rst_q, r_rst_n;

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_rst_q <= 1'b0;
      r_rst_n <= 1'b0;
    end else begin
      r_rst_q <= 1'b1;
      r_rst_n <= r_rst_q;
    end
  end

  logic [DATA_W-1:0]    r_s1_bsk;
  logic [COEF_NB-1:0]   r_s1_avail;
  logic [UNIT_W-1:0]    r_s1_unit;
  logic [GROUP_W-1:0]   r_s1_group;
  logic [BR_LOOP_W-1:0] r_s1_loop;

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_s1_bsk   <= '0;
      r_s1_avail <= '0;
      r_s1_unit  <= '0;
      r_s1_group <= '0;
      r_s1_loop  <= '0;
    end else begin
      r_s1_bsk   <= srv_bdc_bsk;
      r_s1_avail <= srv_bdc_avail;
      r_s1_unit  <= srv_bdc_unit;
      r_s1_group <= srv_bdc_group;
      r_s1_loop  <= srv_bdc_br_loop;
    end
  end

  slot_st_t             r_state     [SLOT_NB];
  logic [BR_LOOP_W-1:0] r_slot_loop [SLOT_NB];
  logic [SLOT_W-1:0]    r_wp_slot, r_rp_slot, r_iss_slot;
  logic [ITER_W-1:0]    r_wr_cnt, r_iss_beat;
  logic                 r_drop;
  logic [3:0]           r_err;

  logic                 r_rd_vld, r_rd_last;
  logic [BR_LOOP_W-1:0] r_rd_loop;
  logic [DATA_W-1:0]    r_ram_q;
  logic                 r_out_vld, r_out_last;
  logic [BR_LOOP_W-1:0] r_out_loop;
  logic [DATA_W-1:0]    r_out_bsk;
  logic                 r_sk_vld, r_sk_last;
  logic [BR_LOOP_W-1:0] r_sk_loop;
  logic [DATA_W-1:0]    r_sk_bsk;
  logic [DATA_W-1:0]    r_ram [DEPTH];

  logic              w_s1_vld, w_first, w_last_in;
  logic              w_pop, w_free_now, w_wp_free;
  logic              w_ovf, w_drop, w_wr_en, w_loop_bad;
  logic              w_iss, w_iss_last, w_room;
  logic [1:0]        w_occ;
  logic [ITER_W-1:0] w_idx;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;

  assign w_s1_vld  = |r_s1_avail;
  assign w_idx     = ITER_W'(r_s1_group) * ITER_W'(UNIT_NB)
                   + ITER_W'(r_s1_unit);
  assign w_first   = (r_wr_cnt == '0);
  assign w_last_in = (r_wr_cnt == ITER_W'(ITER_NB - 1));

  // A slot released by the consumer this cycle is already reusable.
  assign w_pop      = r_out_vld & cl_rdy;
  assign w_free_now = w_pop & r_out_last & (r_rp_slot == r_wp_slot);
  assign w_wp_free  = (r_state[r_wp_slot] == S_FREE) | w_free_now;
  assign w_ovf      = w_s1_vld & w_first & ~w_wp_free;
  assign w_drop     = w_first ? ~w_wp_free : r_drop;
  assign w_wr_en    = w_s1_vld & ~w_drop;
  assign w_wr_addr  = ADDR_W'(r_wp_slot) * ADDR_W'(ITER_NB)
                    + ADDR_W'(w_idx);
  assign w_loop_bad = w_s1_vld & ~w_first & ~r_drop
                    & (r_s1_loop != r_slot_loop[r_wp_slot]);

  // Beats in RAM pipe plus skid buffer never exceed two.
  assign w_occ      = 2'(r_out_vld) + 2'(r_sk_vld) + 2'(r_rd_vld);
  assign w_room     = (w_occ - 2'(w_pop)) < 2'd2;
  assign w_iss      = (r_state[r_iss_slot] == S_FULL) & w_room;
  assign w_iss_last = (r_iss_beat == ITER_W'(ITER_NB - 1));
  assign w_rd_addr  = ADDR_W'(r_iss_slot) * ADDR_W'(ITER_NB)
                    + ADDR_W'(r_iss_beat);

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      for (int i = 0; i < SLOT_NB; i++) begin
        r_state[i]     <= S_FREE;
        r_slot_loop[i] <= '0;
      end
      r_wp_slot  <= '0;
      r_rp_slot  <= '0;
      r_iss_slot <= '0;
      r_wr_cnt   <= '0;
      r_iss_beat <= '0;
      r_drop     <= 1'b0;
      r_err      <= '0;
    end else begin
      if (w_pop & r_out_last) begin
        r_state[r_rp_slot] <= S_FREE;
        r_rp_slot          <= r_rp_slot + 1'b1;
      end
      if (w_iss) begin
        r_iss_beat <= w_iss_last ? '0 : r_iss_beat + 1'b1;
        if (w_iss_last) begin
          r_state[r_iss_slot] <= S_DRAIN;
          r_iss_slot          <= r_iss_slot + 1'b1;
        end
      end
      if (w_s1_vld) begin
        r_drop   <= w_drop;
        r_wr_cnt <= w_last_in ? '0 : r_wr_cnt + 1'b1;
        if (w_first & ~w_drop) begin
          r_state[r_wp_slot]     <= S_FILL;
          r_slot_loop[r_wp_slot] <= r_s1_loop;
        end
        if (w_last_in & ~w_drop) begin
          r_state[r_wp_slot] <= S_FULL;
          r_wp_slot          <= r_wp_slot + 1'b1;
        end
        r_err[3] <= r_err[3] | (w_idx != r_wr_cnt);
        r_err[2] <= r_err[2] | ~(&r_s1_avail);
        r_err[1] <= r_err[1] | w_loop_bad;
        r_err[0] <= r_err[0] | w_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_ram[w_wr_addr] <= r_s1_bsk;
    end
    r_ram_q <= r_ram[w_rd_addr];
  end

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_rd_vld   <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_loop  <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_loop <= '0;
      r_out_bsk  <= '0;
      r_sk_vld   <= 1'b0;
      r_sk_last  <= 1'b0;
      r_sk_loop  <= '0;
      r_sk_bsk   <= '0;
    end else begin
      r_rd_vld  <= w_iss;
      r_rd_last <= w_iss_last;
      r_rd_loop <= r_slot_loop[r_iss_slot];
      if (!r_out_vld | w_pop) begin
        if (r_sk_vld) begin
          r_out_bsk  <= r_sk_bsk;
          r_out_loop <= r_sk_loop;
          r_out_last <= r_sk_last;
          r_sk_vld   <= r_rd_vld;
          if (r_rd_vld) begin
            r_sk_bsk  <= r_ram_q;
            r_sk_loop <= r_rd_loop;
            r_sk_last <= r_rd_last;
          end
        end else begin
          r_out_vld <= r_rd_vld;
          if (r_rd_vld) begin
            r_out_bsk  <= r_ram_q;
            r_out_loop <= r_rd_loop;
            r_out_last <= r_rd_last;
          end
        end
      end else if (r_rd_vld) begin
        r_sk_vld  <= 1'b1;
        r_sk_bsk  <= r_ram_q;
        r_sk_loop <= r_rd_loop;
        r_sk_last <= r_rd_last;
      end
    end
  end

  assign cl_bsk     = r_out_bsk;
  assign cl_vld     = r_out_vld;
  assign cl_br_loop = r_out_loop;
  assign cl_last    = r_out_last;
  assign error      = r_err;

endmodule

// File: tb/tb_bsk_ntw_client.sv
// Randomized bench for bsk_ntw_client against a batch-level
// reference model (address-ordered batches, slot occupancy count).
module tb_bsk_ntw_client;

  localparam int OP_W      = 32;
  localparam int COEF_NB   = 4;
  localparam int UNIT_NB   = 2;
  localparam int GROUP_NB  = 2;
  localparam int SLOT_NB   = 2;
  localparam int BR_LOOP_W = 10;
  localparam int ITER_NB   = UNIT_NB * GROUP_NB;
  localparam int DW        = COEF_NB * OP_W;

  logic                 clk = 1'b0;
  logic                 s_rst_n = 1'b1;
  logic [DW-1:0]        srv_bdc_bsk;
  logic [COEF_NB-1:0]   srv_bdc_avail;
  logic [0:0]           srv_bdc_unit;
  logic [0:0]           srv_bdc_group;
  logic [BR_LOOP_W-1:0] srv_bdc_br_loop;
  logic [DW-1:0]        cl_bsk;
  logic                 cl_vld;
  logic                 cl_rdy = 1'b0;
  logic [BR_LOOP_W-1:0] cl_br_loop;
  logic                 cl_last;
  logic [3:0]           error;

  bsk_ntw_client #(
    .OP_W(OP_W), .COEF_NB(COEF_NB), .UNIT_NB(UNIT_NB),
    .GROUP_NB(GROUP_NB), .SLOT_NB(SLOT_NB), .BR_LOOP_W(BR_LOOP_W)
  ) dut (
    .clk(clk), .s_rst_n(s_rst_n),
    .srv_bdc_bsk(srv_bdc_bsk), .srv_bdc_avail(srv_bdc_avail),
    .srv_bdc_unit(srv_bdc_unit), .srv_bdc_group(srv_bdc_group),
    .srv_bdc_br_loop(srv_bdc_br_loop),
    .cl_bsk(cl_bsk), .cl_vld(cl_vld), .cl_rdy(cl_rdy),
    .cl_br_loop(cl_br_loop), .cl_last(cl_last), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]        d;
    logic [BR_LOOP_W-1:0] l;
    logic                 last;
  } beat_t;

  beat_t exp_q[$];
  beat_t e_mon, prev;
  logic  prev_stall = 1'b0;
  int    vectors = 0;
  int    errors = 0;
  int    pending = 0;
  int    hs_cnt = 0;
  int    rdy_mode = 0;
  logic [3:0] exp_err = 4'd0;

  int                 b_g[ITER_NB];
  int                 b_u[ITER_NB];
  int                 b_loop[ITER_NB];
  logic [COEF_NB-1:0] b_avail[ITER_NB];
  logic [DW-1:0]      b_data[ITER_NB];

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       cl_rdy = 1'b0;
      1:       cl_rdy = 1'b1;
      default: cl_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!s_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        vectors++;
        if (!cl_vld || cl_bsk !== prev.d || cl_br_loop !== prev.l ||
            cl_last !== prev.last) begin
          errors++;
          $display("FAIL stall_stable got vld=%0b l=%0d last=%0b exp l=%0d last=%0b",
                   cl_vld, cl_br_loop, cl_last, prev.l, prev.last);
        end
      end
      if (cl_vld && cl_rdy) begin
        vectors++;
        hs_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_beat got unexpected beat l=%0d last=%0b exp none",
                   cl_br_loop, cl_last);
        end else begin
          e_mon = exp_q.pop_front();
          if (cl_bsk !== e_mon.d || cl_br_loop !== e_mon.l ||
              cl_last !== e_mon.last) begin
            errors++;
            $display("FAIL out_beat got d=%h l=%0d last=%0b exp d=%h l=%0d last=%0b",
                     cl_bsk, cl_br_loop, cl_last, e_mon.d, e_mon.l, e_mon.last);
          end
          if (e_mon.last) pending--;
        end
      end
      prev_stall = cl_vld && !cl_rdy;
      prev.d = cl_bsk;
      prev.l = cl_br_loop;
      prev.last = cl_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    srv_bdc_bsk     = '0;
    srv_bdc_avail   = '0;
    srv_bdc_unit    = '0;
    srv_bdc_group   = '0;
    srv_bdc_br_loop = '0;
  endtask

  task automatic do_reset();
    s_rst_n = 1'b0;
    rdy_mode = 0;
    idle();
    tick();
    tick();
    exp_q.delete();
    pending = 0;
    exp_err = 4'd0;
    s_rst_n = 1'b1;
    repeat (4) tick();
  endtask

  function automatic logic [DW-1:0] rep(input int v);
    return {COEF_NB{32'(v)}};
  endfunction

  task automatic fill(input int loop, input bit rnd);
    for (int i = 0; i < ITER_NB; i++) begin
      b_g[i]     = i / UNIT_NB;
      b_u[i]     = i % UNIT_NB;
      b_loop[i]  = loop;
      b_avail[i] = '1;
      b_data[i]  = rnd ? {$urandom, $urandom, $urandom, $urandom} : rep(i);
    end
  endtask

  task automatic drive_beat(input int i);
    srv_bdc_bsk     = b_data[i];
    srv_bdc_avail   = b_avail[i];
    srv_bdc_unit    = 1'(b_u[i]);
    srv_bdc_group   = 1'(b_g[i]);
    srv_bdc_br_loop = BR_LOOP_W'(b_loop[i]);
  endtask

  // Batch-level model: a batch is kept iff a slot is free when it starts;
  // its output is the data indexed by group*UNIT_NB+unit, in address order.
  task automatic send_batch();
    bit    ok;
    beat_t ob[ITER_NB];
    ok = pending < SLOT_NB;
    for (int i = 0; i < ITER_NB; i++) begin
      drive_beat(i);
      tick();
    end
    idle();
    if (!ok) exp_err[0] = 1'b1;
    for (int i = 0; i < ITER_NB; i++) begin
      if (b_g[i] * UNIT_NB + b_u[i] != i) exp_err[3] = 1'b1;
      if (b_avail[i] != 4'hF) exp_err[2] = 1'b1;
      if (ok && i > 0 && b_loop[i] != b_loop[0]) exp_err[1] = 1'b1;
      ob[b_g[i] * UNIT_NB + b_u[i]].d = b_data[i];
    end
    if (ok) begin
      for (int a = 0; a < ITER_NB; a++) begin
        ob[a].l = BR_LOOP_W'(b_loop[0]);
        ob[a].last = (a == ITER_NB - 1);
        exp_q.push_back(ob[a]);
      end
      pending++;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    repeat (6) tick();
  endtask

  task automatic test_reset();
    s_rst_n = 1'b0;
    idle();
    repeat (3) tick();
    vectors++;
    if ({cl_vld, cl_last, cl_br_loop, error} !== '0 || cl_bsk !== '0) begin
      errors++;
      $display("FAIL reset_held got vld=%0b last=%0b loop=%0d err=%b exp 0",
               cl_vld, cl_last, cl_br_loop, error);
    end
    s_rst_n = 1'b1;
    repeat (4) tick();
    vectors++;
    if ({cl_vld, cl_last, cl_br_loop, error} !== '0 || cl_bsk !== '0) begin
      errors++;
      $display("FAIL reset_release got vld=%0b err=%b exp 0", cl_vld, error);
    end
  endtask

  task automatic test_basic();
    do_reset();
    rdy_mode = 1;
    fill(5, 1'b0);
    send_batch();
    tick();
    tick();
    vectors++;
    if (cl_vld !== 1'b0) begin
      errors++;
      $display("FAIL latency_early got vld=%0b exp 0", cl_vld);
    end
    tick();
    vectors++;
    if (cl_vld !== 1'b1) begin
      errors++;
      $display("FAIL latency_first got vld=%0b exp 1", cl_vld);
    end
    wait_drain();
    vectors++;
    if (exp_q.size() != 0 || error !== 4'b0000) begin
      errors++;
      $display("FAIL basic_done got left=%0d err=%b exp left=0 err=0000",
               exp_q.size(), error);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    rdy_mode = 0;
    for (int k = 1; k <= 3; k++) begin
      fill(k, 1'b1);
      send_batch();
    end
    repeat (4) tick();
    vectors++;
    if (error !== exp_err || exp_err !== 4'b0001) begin
      errors++;
      $display("FAIL overflow_err got %b exp %b", error, exp_err);
    end
    rdy_mode = 1;
    wait_drain();
    vectors++;
    if (exp_q.size() != 0 || pending != 0) begin
      errors++;
      $display("FAIL overflow_drain got left=%0d exp 0", exp_q.size());
    end
  endtask

  task automatic test_order();
    do_reset();
    rdy_mode = 1;
    fill(5, 1'b0);
    b_g[1] = 1; b_u[1] = 0;
    b_g[2] = 0; b_u[2] = 1;
    send_batch();
    wait_drain();
    vectors++;
    if (exp_q.size() != 0 || error !== 4'b1000) begin
      errors++;
      $display("FAIL order_err got left=%0d err=%b exp left=0 err=1000",
               exp_q.size(), error);
    end
  endtask

  task automatic test_partial();
    do_reset();
    rdy_mode = 1;
    fill(5, 1'b1);
    b_avail[1] = 4'b0011;
    send_batch();
    wait_drain();
    vectors++;
    if (exp_q.size() != 0 || error !== 4'b0100) begin
      errors++;
      $display("FAIL partial_err got left=%0d err=%b exp left=0 err=0100",
               exp_q.size(), error);
    end
  endtask

  task automatic test_loop();
    do_reset();
    rdy_mode = 1;
    fill(5, 1'b1);
    b_loop[2] = 6;
    send_batch();
    wait_drain();
    vectors++;
    if (exp_q.size() != 0 || error !== 4'b0010) begin
      errors++;
      $display("FAIL loop_err got left=%0d err=%b exp left=0 err=0010",
               exp_q.size(), error);
    end
  endtask

  task automatic test_random();
    int hs0;
    int wcnt;
    do_reset();
    rdy_mode = 2;
    hs0 = hs_cnt;
    for (int k = 0; k < 8; k++) begin
      wcnt = 0;
      while (pending >= SLOT_NB && wcnt < 400) begin
        tick();
        wcnt++;
      end
      vectors++;
      if (pending >= SLOT_NB) begin
        errors++;
        $display("FAIL pace_timeout got pending=%0d exp <%0d", pending, SLOT_NB);
      end
      repeat ($urandom_range(0, 3)) tick();
      fill(int'($urandom_range(0, 1023)), 1'b1);
      send_batch();
    end
    wait_drain();
    vectors++;
    if (exp_q.size() != 0 || hs_cnt - hs0 != 8 * ITER_NB || error !== 4'b0000) begin
      errors++;
      $display("FAIL random_stream got beats=%0d left=%0d err=%b exp beats=%0d left=0 err=0000",
               hs_cnt - hs0, exp_q.size(), error, 8 * ITER_NB);
    end
  endtask

  task automatic test_mid_reset();
    rdy_mode = 1;
    fill(7, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive_beat(i);
      tick();
    end
    s_rst_n = 1'b0;
    idle();
    tick();
    tick();
    exp_q.delete();
    pending = 0;
    exp_err = 4'd0;
    s_rst_n = 1'b1;
    repeat (4) tick();
    vectors++;
    if (error !== 4'b0000 || cl_vld !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state got err=%b vld=%0b exp 0000 0", error, cl_vld);
    end
    fill(9, 1'b1);
    send_batch();
    wait_drain();
    vectors++;
    if (exp_q.size() != 0 || error !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_batch got left=%0d err=%b exp left=0 err=0000",
               exp_q.size(), error);
    end
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_basic();
    test_overflow();
    test_order();
    test_partial();
    test_loop();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
